sipo_deser: RTL



---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_fifo2.sv | 65 ++++++
 rtl/sipo_deser.sv | 107 ++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/sipo_fifo2.sv
// Two-entry synchronous FIFO; the head entry drives rdata_o directly.
module sipo_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with start-bit framing,
// selectable bit order, 2-entry output FIFO and sticky error flags.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             sin_i,
    input  logic             sin_en_i,
    input  logic             sin_start_i,
    input  logic             lsb_first_i,
    output logic [WIDTH-1:0] pdata_o,
    output logic             pvalid_o,
    input  logic             pready_i,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             frame_err_o,
    input  logic             clr_i
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic             push, pop, full, empty;
    logic             ferr_set, ovf_set;
    logic [1:0]       fifo_cnt;

    assign pop = pvalid_o && pready_i;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        order_d  = order_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (sin_en_i && sin_start_i) begin
            // A start always begins a fresh word; mid-word it is a framing error.
            ferr_set = (state_q == SHIFT);
            order_d  = lsb_first_i;
            sh_d     = (lsb_first_i == ORDER_LSB)
                     ? {sin_i, {(WIDTH-1){1'b0}}}
                     : {{(WIDTH-1){1'b0}}, sin_i};
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
        end else if (sin_en_i && state_q == SHIFT) begin
            sh_d  = (order_q == ORDER_LSB)
                  ? {sin_i, sh_q[WIDTH-1:1]}
                  : {sh_q[WIDTH-2:0], sin_i};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                push    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
        ovf_set = push && full && !pop;
        ovf_d   = (ovf_q && !clr_i) || ovf_set;
        ferr_d  = (ferr_q && !clr_i) || ferr_set;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_MSB;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    sipo_fifo2 #(
        .W(WIDTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (sh_d),
        .rdata_o (pdata_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );

    assign pvalid_o    = !empty;
    assign bit_cnt_o   = cnt_q;
    assign busy_o      = (state_q == SHIFT);
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;

endmodule
